regfile_responder: RTL



---
 rtl/regfile_pkg.sv | 39 +++
 rtl/regfile_dump_fsm.sv | 88 ++++++++
 rtl/regfile_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants, types and helpers for the integer register file
//   (regfile_responder) and its register-dump state machine
//   (regfile_dump_fsm).
//
//   Contents:
//     XLEN             default data width of one register
//     REG_COUNT        number of architectural registers
//     IDX_W            width of a register index
//     LAST_IDX         index of the final register (end of a dump)
//     PENULT_IDX       index just before LAST_IDX
//     SP_INIT_DEFAULT  default reset value of x2 (stack pointer)
//     dump_state_t     dump FSM state encoding {IDLE, SEND}
//     addr_valid()     32-bit address is in range iff bits [31:IDX_W] are zero
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int IDX_W     = 5;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(REG_COUNT - 2);

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_0FFC;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

  // The decode stage hands us full 32-bit address fields; only the low
  // IDX_W bits select a register and any other set bit means "out of range".
  function automatic logic addr_valid(input logic [31:0] addr);
    return (addr[31:IDX_W] == '0);
  endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// -----------------------------------------------------------------------------
// regfile_dump_fsm
//   Sequencer for the valid/ready register-dump stream. It walks dump_idx from
//   0 to 31, one beat per accepted handshake, and returns to IDLE after the
//   last beat. The data for the current beat is looked up by the parent from
//   the live register array using dump_idx, so this block only owns the index
//   and the handshake/status flags.
//
//   Ports:
//     clk         in   clock
//     reset_n     in   asynchronous active-low reset
//     dump_req    in   start request, level-sampled while IDLE
//     dump_ready  in   consumer accepts the current beat
//     dump_valid  out  beat valid (registered)
//     dump_idx    out  register index of the current beat (registered)
//     dump_last   out  current beat is the final register (registered)
//     dump_busy   out  a dump is in progress (registered)
// -----------------------------------------------------------------------------
module regfile_dump_fsm
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dump_req,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [IDX_W-1:0] dump_idx,
  output logic             dump_last,
  output logic             dump_busy
);

  dump_state_t state_reg;

  // All outputs are registered alongside the state so the consumer sees
  // glitch-free handshake signals. Because the reset is asynchronous,
  // dump_valid/dump_busy fall the moment reset_n is asserted, abandoning
  // any partial dump.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      dump_idx   <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      dump_busy  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dump_req) begin
            state_reg  <= SEND;
            dump_idx   <= '0;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
            dump_last  <= 1'b0;
          end
        end

        SEND: begin
          // dump_req is deliberately ignored here; a new dump can only be
          // requested once we are back in IDLE, which guarantees at least
          // one idle cycle between consecutive dumps.
          if (dump_ready) begin
            if (dump_idx == LAST_IDX) begin
              state_reg  <= IDLE;
              dump_idx   <= '0;
              dump_valid <= 1'b0;
              dump_busy  <= 1'b0;
              dump_last  <= 1'b0;
            end else begin
              dump_idx  <= dump_idx + 1'b1;
              // The next beat is the last one when we are moving off the
              // penultimate index.
              dump_last <= (dump_idx == PENULT_IDX);
            end
          end
        end

        default: begin
          state_reg  <= IDLE;
          dump_idx   <= '0;
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
          dump_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_responder.sv
// -----------------------------------------------------------------------------
// regfile_responder
//   32 x XLEN integer register file for the decode stage: two combinational
//   read ports, one synchronous write port, a sticky out-of-range address
//   flag and a valid/ready register-dump stream.
//
//   x0 is hardwired to zero; x2 (sp) resets to SP_INIT, all others to zero.
//   Addresses arrive as full 32-bit fields; an address is in range only when
//   bits [31:5] are zero. Out-of-range reads return zero, out-of-range writes
//   are dropped, and either sets addr_err until reset.
//
//   Build option:
//     REGFILE_BYPASS_EN  when defined (and BYPASS_DEFAULT=1) a write to the
//                        same valid, nonzero index being read in the same
//                        cycle is forwarded to that read port. When undefined
//                        reads return the pre-write contents. The dump port
//                        is never forwarded.
//
//   Ports:
//     clk         in   clock
//     reset_n     in   asynchronous active-low reset
//     rd_addr1    in   read address, port 1
//     rd_addr2    in   read address, port 2
//     rd_data1    out  read data, port 1 (combinational)
//     rd_data2    out  read data, port 2 (combinational)
//     wr_en       in   write enable
//     wr_addr     in   write address
//     wr_data     in   write data
//     dump_req    in   start a register dump (sampled while idle)
//     dump_valid  out  dump beat valid
//     dump_ready  in   dump consumer accepts beat
//     dump_idx    out  register index of current dump beat
//     dump_data   out  live contents of register dump_idx
//     dump_last   out  current dump beat is register 31
//     dump_busy   out  dump in progress
//     addr_err    out  sticky out-of-range address flag
// -----------------------------------------------------------------------------
module regfile_responder #(
  parameter int              XLEN           = regfile_pkg::XLEN,
  parameter logic [XLEN-1:0] SP_INIT        = XLEN'(regfile_pkg::SP_INIT_DEFAULT),
  parameter bit              BYPASS_DEFAULT = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     rd_addr1,
  input  logic [31:0]     rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  input  logic            wr_en,
  input  logic [31:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            dump_req,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [4:0]      dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_last,
  output logic            dump_busy,
  output logic            addr_err
);

  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_ON = BYPASS_DEFAULT;
`else
  // Forwarding is compiled out; the parameter is still referenced so both
  // builds present the same parameter interface.
  localparam bit BYPASS_ON = 1'b0 & BYPASS_DEFAULT;
`endif

  localparam int SP_IDX = 2;

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  regs [REG_COUNT];
  logic [IDX_W-1:0] wr_idx;
  logic             wr_ok;

  assign wr_idx = wr_addr[IDX_W-1:0];
  // Writes to x0 and out-of-range writes are dropped here; x0 therefore keeps
  // its reset value of zero forever, which lets every read path index the
  // array directly without a separate x0 special case.
  assign wr_ok  = wr_en && addr_valid(wr_addr) && (wr_idx != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wr_ok) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports (identical logic, built per port)
  // ---------------------------------------------------------------------------
  logic [31:0]     rd_addr_vec [2];
  logic [XLEN-1:0] rd_data_vec [2];

  assign rd_addr_vec[0] = rd_addr1;
  assign rd_addr_vec[1] = rd_addr2;
  assign rd_data1       = rd_data_vec[0];
  assign rd_data2       = rd_data_vec[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      logic [IDX_W-1:0] rd_idx;
      logic             rd_ok;
      logic             fwd_hit;

      assign rd_idx = rd_addr_vec[gi][IDX_W-1:0];
      assign rd_ok  = addr_valid(rd_addr_vec[gi]);
      // wr_ok already implies a valid, nonzero index, so full-address
      // equality is enough to identify a same-register collision.
      assign fwd_hit = BYPASS_ON && wr_ok && (wr_addr == rd_addr_vec[gi]);

      assign rd_data_vec[gi] = !rd_ok  ? '0 :
                               fwd_hit ? wr_data :
                                         regs[rd_idx];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sticky out-of-range flag
  // ---------------------------------------------------------------------------
  // Both read ports are always "in use" (combinational, no enable), so a bad
  // read address counts whenever it is presented; a bad write address only
  // counts when a write is actually requested.
  logic addr_err_reg;
  logic addr_err_next;

  assign addr_err_next = !addr_valid(rd_addr1) ||
                         !addr_valid(rd_addr2) ||
                         (wr_en && !addr_valid(wr_addr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_err_reg <= 1'b0;
    end else if (addr_err_next) begin
      addr_err_reg <= 1'b1;
    end
  end

  assign addr_err = addr_err_reg;

  // ---------------------------------------------------------------------------
  // Register dump stream
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] dump_idx_int;

  regfile_dump_fsm u_dump_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx_int),
    .dump_last  (dump_last),
    .dump_busy  (dump_busy)
  );

  assign dump_idx  = dump_idx_int;
  // Third read mux: live view of the array, never forwarded, so a write to
  // the current index shows up on dump_data the cycle after it lands.
  assign dump_data = regs[dump_idx_int];

endmodule
